// File: rtl/nios_system_timer_ctrl_master.sv
// Avalon-MM initiator turning accelerator commands into interval-timer s1 register sequences; TIMER_CTRL_AUTOACK_EN adds irq auto-ack + tick.
// Latency: bus starts the cycle after acceptance, rsp_valid the cycle after the last bus cycle (START 2 .. SNAPSHOT 6 at READ_WAIT=2).
// Backpressure: cmd_ready only in IDLE (and, with auto-ack, only while irq is low); one command in flight.
module nios_system_timer_ctrl_master #(
    parameter int READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_period,
    input  logic        cmd_cont,
    input  logic        cmd_ito,
    input  logic        cmd_clear,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        irq,
    output logic        tick,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    input  logic [15:0] readdata
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RSP  = 3'd3;
`ifdef TIMER_CTRL_AUTOACK_EN
    localparam logic [2:0] S_ACK  = 3'd4;
`endif

    localparam logic [2:0] OP_SET_PERIOD = 3'd0;
    localparam logic [2:0] OP_START      = 3'd1;
    localparam logic [2:0] OP_STOP       = 3'd2;
    localparam logic [2:0] OP_SNAPSHOT   = 3'd3;
    localparam logic [2:0] OP_STATUS     = 3'd4;

    localparam int            WW        = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(READ_WAIT - 1);

    typedef struct packed {
        logic        last;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    // Each command is a short script of accesses indexed by step.
    function automatic acc_t acc_f(input logic [2:0] op, input logic [1:0] step, input logic clr,
                                   input logic [31:0] per, input logic cont, input logic ito);
        acc_t a;
        a      = '0;
        a.last = 1'b1;
        case (op)
            OP_SET_PERIOD: begin
                a.last = step[0];
                a.addr = step[0] ? 3'd3 : 3'd2;
                a.data = step[0] ? per[31:16] : per[15:0];
            end
            OP_START: begin
                a.addr = 3'd1;
                a.data = {12'd0, 2'b01, cont, ito};
            end
            OP_STOP: begin
                a.addr = 3'd1;
                a.data = {12'd0, 2'b10, cont, ito};
            end
            OP_SNAPSHOT: begin
                a.last = (step == 2'd2);
                a.addr = (step == 2'd2) ? 3'd5 : 3'd4;
            end
            OP_STATUS: a.last = (step != 2'd0) || !clr;
            default: ;
        endcase
        return a;
    endfunction

    function automatic logic step_is_rd(input logic [2:0] op, input logic [1:0] step);
        return ((op == OP_SNAPSHOT) && (step != 2'd0)) || ((op == OP_STATUS) && (step == 2'd0));
    endfunction

    logic [2:0]    state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   period_q, period_d;
    logic          cont_q, cont_d;
    logic          ito_q, ito_d;
    logic          clear_q, clear_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          advance;
    acc_t          cur;

    assign cur = acc_f(op_q, step_q, clear_q, period_q, cont_q, ito_q);

`ifdef TIMER_CTRL_AUTOACK_EN
    assign cmd_ready = (state_q == S_IDLE) && !irq;
    assign tick      = (state_q == S_ACK);
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign cmd_ready  = (state_q == S_IDLE);
    assign tick       = 1'b0;
`endif
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        wait_d     = wait_q;
        op_d       = op_q;
        period_d   = period_q;
        cont_d     = cont_q;
        ito_d      = ito_q;
        clear_d    = clear_q;
        rsp_data_d = rsp_data_q;
        advance    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d     = cmd_op;
                    period_d = cmd_period;
                    cont_d   = cmd_cont;
                    ito_d    = cmd_ito;
                    clear_d  = cmd_clear;
                    step_d   = 2'd0;
                    wait_d   = '0;
                    if (cmd_op > OP_STATUS)
                        state_d = S_RSP;
                    else
                        state_d = step_is_rd(cmd_op, 2'd0) ? S_RD : S_WR;
                end
`ifdef TIMER_CTRL_AUTOACK_EN
                if (irq)
                    state_d = S_ACK;
`endif
            end
            S_WR: advance = 1'b1;
            S_RD: begin
                if (wait_q == WAIT_LAST) begin
                    advance = 1'b1;
                    if (op_q == OP_STATUS)
                        rsp_data_d = {30'd0, readdata[1:0]};
                    else if (cur.addr == 3'd5)
                        rsp_data_d[31:16] = readdata;
                    else
                        rsp_data_d[15:0] = readdata;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            if (cur.last) begin
                state_d = S_RSP;
            end else begin
                step_d  = step_q + 2'd1;
                wait_d  = '0;
                state_d = step_is_rd(op_q, step_q + 2'd1) ? S_RD : S_WR;
            end
        end
    end

    // Bus is idle except in WR/RD/ACK; reads hold address with chipselect low.
    always_comb begin
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'd0;
        case (state_q)
            S_WR: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = cur.addr;
                writedata  = cur.data;
            end
            S_RD: address = cur.addr;
`ifdef TIMER_CTRL_AUTOACK_EN
            S_ACK: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_q     <= 2'd0;
            wait_q     <= '0;
            op_q       <= 3'd0;
            period_q   <= 32'd0;
            cont_q     <= 1'b0;
            ito_q      <= 1'b0;
            clear_q    <= 1'b0;
            rsp_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wait_q     <= wait_d;
            op_q       <= op_d;
            period_q   <= period_d;
            cont_q     <= cont_d;
            ito_q      <= ito_d;
            clear_q    <= clear_d;
            rsp_data_q <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_nios_system_timer_ctrl_master.sv
// Bench for nios_system_timer_ctrl_master: behavioural interval-timer slave, per-command expected bus scripts, random command mix.
`timescale 1ns/1ps
module tb_nios_system_timer_ctrl_master;
    localparam int READ_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_period = 32'd0;
    logic        cmd_cont = 1'b0;
    logic        cmd_ito = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        irq;
    logic        tick;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    always #5 clk = ~clk;

    nios_system_timer_ctrl_master #(.READ_WAIT(READ_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_period(cmd_period),
        .cmd_cont(cmd_cont), .cmd_ito(cmd_ito), .cmd_clear(cmd_clear),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .irq(irq), .tick(tick),
        .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata)
    );

    // Interval timer slave model: down-counter, timeout flag, snapshot, registered readdata.
    logic        t_run, t_to, t_ito, t_cont;
    logic [31:0] t_period, t_cnt, t_snap;
    logic [15:0] t_rd;
    always @(posedge clk) begin
        if (reset) begin
            t_run <= 0; t_to <= 0; t_ito <= 0; t_cont <= 0;
            t_period <= 0; t_cnt <= 0; t_snap <= 0; t_rd <= 0;
        end else begin
            case (address)
                3'd0:    t_rd <= {14'd0, t_run, t_to};
                3'd1:    t_rd <= {14'd0, t_cont, t_ito};
                3'd2:    t_rd <= t_period[15:0];
                3'd3:    t_rd <= t_period[31:16];
                3'd4:    t_rd <= t_snap[15:0];
                3'd5:    t_rd <= t_snap[31:16];
                default: t_rd <= 16'd0;
            endcase
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_to  <= 1'b1;
                    t_cnt <= t_period;
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 1;
                end
            end
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= writedata[0];
                        t_cont <= writedata[1];
                        if (writedata[2]) t_run <= 1'b1;
                        if (writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: begin t_period[15:0]  <= writedata; t_cnt <= {t_period[31:16], writedata}; end
                    3'd3: begin t_period[31:16] <= writedata; t_cnt <= {writedata, t_period[15:0]}; end
                    3'd4, 3'd5: t_snap <= t_cnt;
                    default: ;
                endcase
            end
        end
    end
    assign readdata = t_rd;
    assign irq      = t_to & t_ito;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rsp = 32'd0;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        cap;
    } cyc_t;
    cyc_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back({1'b1, a, d, 1'b0});
    endtask

    task automatic push_rd(input logic [2:0] a);
        for (int i = 0; i < READ_WAIT; i++)
            exp_q.push_back({1'b0, a, 16'd0, (i == READ_WAIT - 1)});
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic exp_ready_idle();
`ifdef TIMER_CTRL_AUTOACK_EN
        return !irq;
`else
        return 1'b1;
`endif
    endfunction

    // Issues one command from a negedge and checks every bus cycle plus the response.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] per, input logic cont,
                          input logic ito, input logic clr);
        bit ok;
        exp_q.delete();
        case (op)
            3'd0: begin push_wr(3'd2, per[15:0]); push_wr(3'd3, per[31:16]); end
            3'd1: push_wr(3'd1, {12'd0, 2'b01, cont, ito});
            3'd2: push_wr(3'd1, {12'd0, 2'b10, cont, ito});
            3'd3: begin push_wr(3'd4, 16'd0); push_rd(3'd4); push_rd(3'd5); end
            3'd4: begin push_rd(3'd0); if (clr) push_wr(3'd0, 16'd0); end
            default: ;
        endcase
        wait_ready(ok);
        check("ready_wait", {31'd0, ok}, 32'd1);
        if (!ok) return;
        cmd_valid = 1'b1; cmd_op = op; cmd_period = per;
        cmd_cont = cont; cmd_ito = ito; cmd_clear = clr;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_period = $urandom; cmd_op = 3'($urandom);
        cmd_cont = 1'($urandom); cmd_ito = 1'($urandom); cmd_clear = 1'($urandom);
        foreach (exp_q[i]) begin
            check("bus_cs", {31'd0, chipselect}, {31'd0, exp_q[i].wr});
            check("bus_wn", {31'd0, write_n}, {31'd0, !exp_q[i].wr});
            check("bus_addr", {29'd0, address}, {29'd0, exp_q[i].addr});
            if (exp_q[i].wr) check("bus_wdata", {16'd0, writedata}, {16'd0, exp_q[i].data});
            check("rsp_early", {31'd0, rsp_valid}, 32'd0);
            check("ready_busy", {31'd0, cmd_ready}, 32'd0);
            if (exp_q[i].cap && op == 3'd4) exp_rsp = {30'd0, t_rd[1:0]};
            @(negedge clk);
        end
        if (op == 3'd3) exp_rsp = t_snap;
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_data", rsp_data, exp_rsp);
        @(negedge clk);
        check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        check("ready_again", {31'd0, cmd_ready}, {31'd0, exp_ready_idle()});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        int cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_bus", {26'd0, address, chipselect, write_n, 1'b0}, {26'd0, 3'd0, 1'b0, 1'b1, 1'b0});
        check("rst_wdata", {16'd0, writedata}, 32'd0);

        do_cmd(3'd0, 32'h0000_0031, 1'b0, 1'b0, 1'b0);
        check("period_loaded", t_period, 32'h31);
        check("counter_loaded", t_cnt, 32'h31);

`ifndef TIMER_CTRL_AUTOACK_EN
        do_cmd(3'd1, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (55) @(negedge clk);
        check("irq_timeout", {31'd0, irq}, 32'd1);
        do_cmd(3'd4, 32'd0, 1'b0, 1'b0, 1'b1);
        check("status_timeout", rsp_data, 32'h1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
`endif

        do_cmd(3'd0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        do_cmd(3'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        do_cmd(3'd3, 32'd0, 1'b0, 1'b0, 1'b0);
        check("snap_bound", {31'd0, rsp_data <= 32'h0001_0000}, 32'd1);
        check("snap_moving", {31'd0, rsp_data < 32'h0001_0000}, 32'd1);

        // Reset while the addr-5 read of a SNAPSHOT is in progress.
        wait_ready(ok);
        check("mid_ready", {31'd0, ok}, 32'd1);
        cmd_valid = 1'b1; cmd_op = 3'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_addr5", {29'd0, address}, 32'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_bus_idle", {26'd0, address, chipselect, write_n, 1'b0}, {26'd0, 3'd0, 1'b0, 1'b1, 1'b0});
        check("mid_wdata", {16'd0, writedata}, 32'd0);
        check("mid_ready_after", {31'd0, cmd_ready}, 32'd1);
        exp_rsp = 32'd0;
        cnt = 0;
        repeat (10) begin
            if (rsp_valid) cnt++;
            @(negedge clk);
        end
        check("mid_no_rsp", cnt, 32'd0);
        do_cmd(3'd4, 32'd0, 1'b0, 1'b0, 1'b0);

`ifdef TIMER_CTRL_AUTOACK_EN
        do_cmd(3'd0, 32'd9, 1'b0, 1'b0, 1'b0);
        do_cmd(3'd1, 32'd0, 1'b1, 1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (irq) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("aa_irq_seen", {31'd0, ok}, 32'd1);
        check("aa_ready_blocked", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_clear = 1'b0;
        @(negedge clk);
        check("aa_ack_write", {27'd0, tick, chipselect, write_n, address[1:0]}, {27'd0, 1'b1, 1'b1, 1'b0, 2'd0});
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_ready) begin ok = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("aa_cmd_accepted", {31'd0, ok}, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("aa_cmd_rsp", {31'd0, ok}, 32'd1);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        check("aa_tick_count", cnt, 32'd10);
        do_cmd(3'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
`endif

        repeat (60) begin
            do_cmd(3'($urandom_range(0, 7)), 32'($urandom_range(30, 400)),
                   1'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
